// File: rtl/cache_ctrl_wb.sv
`default_nettype none
// ============================================================================
//  Module   : cache_ctrl_wb
//  Purpose  : Direct-mapped, write-back, write-allocate cache controller.
//             One word per line, word addressing. Dirty victims are written
//             back before a read fill or before a write miss takes the line.
//  Ports    : clk, rst (async, active low)
//             requester : rd_en, wr_en, addr, wr_data -> rd_data, rd_valid,
//                         hit, stall
//             memory    : mem_rd_en, mem_wr_en, mem_addr, mem_wr_data <-
//                         mem_data, mem_data_valid, mem_wr_ack
//             stats     : hit_count, miss_count (saturating)
//  Revision : 1.0  initial release
// ============================================================================
module cache_ctrl_wb #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int LINES  = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              hit,
    output logic              stall,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_data_valid,
    input  logic              mem_wr_ack,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DATA_W-1:0] r_data [LINES];
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;

    logic [ADDR_W-1:0] r_req_addr;
    logic [DATA_W-1:0] r_req_wdata;
    logic              r_req_wr;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_ridx;
    logic [TAG_W-1:0]  w_rtag;
    logic              w_req;
    logic              w_hit;
    logic              w_miss;
    logic              w_fill_done;

    assign w_idx       = addr[IDX_W-1:0];
    assign w_tag       = addr[ADDR_W-1:IDX_W];
    assign w_ridx      = r_req_addr[IDX_W-1:0];
    assign w_rtag      = r_req_addr[ADDR_W-1:IDX_W];
    assign w_req       = rd_en | wr_en;
    assign w_hit       = (r_state == S_IDLE) && w_req && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss      = (r_state == S_IDLE) && w_req && !w_hit;
    assign w_fill_done = (r_state == S_FILL) && mem_data_valid;

    // Gated by rst so every output reads 0 while reset is held, even if the
    // requester keeps a request asserted.
    assign stall = rst && (w_miss || (r_state == S_WB) || (r_state == S_FILL));

    // Next state and Moore memory-side outputs
    always_comb begin
        w_next      = r_state;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        case (r_state)
            S_IDLE: begin
                if (w_miss) begin
                    if (r_valid[w_idx] && r_dirty[w_idx]) w_next = S_WB;
                    else if (wr_en)                       w_next = S_RESP;
                    else                                  w_next = S_FILL;
                end
            end
            S_WB: begin
                mem_wr_en   = 1'b1;
                mem_addr    = {r_tag[w_ridx], w_ridx};
                mem_wr_data = r_data[w_ridx];
                if (mem_wr_ack) w_next = r_req_wr ? S_RESP : S_FILL;
            end
            S_FILL: begin
                mem_rd_en = 1'b1;
                mem_addr  = r_req_addr;
                if (mem_data_valid) w_next = S_RESP;
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Control state, valid/dirty, request latch, responses and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_wr    <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            hit         <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            r_state  <= w_next;
            rd_valid <= 1'b0;
            hit      <= 1'b0;
            if (w_hit) begin
                hit <= 1'b1;
                if (wr_en) begin
                    r_dirty[w_idx] <= 1'b1;
                end else begin
                    rd_data  <= r_data[w_idx];
                    rd_valid <= 1'b1;
                end
                if (hit_count != C_CNT_MAX) hit_count <= hit_count + C_CNT_ONE;
            end
            if (w_miss) begin
                r_req_addr  <= addr;
                r_req_wdata <= wr_data;
                r_req_wr    <= wr_en;
                if (miss_count != C_CNT_MAX) miss_count <= miss_count + C_CNT_ONE;
            end
            if (w_fill_done) begin
                r_valid[w_ridx] <= 1'b1;
                r_dirty[w_ridx] <= 1'b0;
            end
            if (r_state == S_RESP) begin
                if (r_req_wr) begin
                    r_valid[w_ridx] <= 1'b1;
                    r_dirty[w_ridx] <= 1'b1;
                end else begin
                    // The filled word already sits in the array from FILL.
                    rd_data  <= r_data[w_ridx];
                    rd_valid <= 1'b1;
                end
            end
        end
    end

    // Data and tag storage carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_hit && wr_en) begin
            r_data[w_idx] <= wr_data;
        end
        if (w_fill_done) begin
            r_data[w_ridx] <= mem_data;
            r_tag[w_ridx]  <= w_rtag;
        end
        if ((r_state == S_RESP) && r_req_wr) begin
            r_data[w_ridx] <= r_req_wdata;
            r_tag[w_ridx]  <= w_rtag;
        end
    end

endmodule
`default_nettype wire
